fall_alarm_controller: RTL and testbench
========================================

Name: fall_alarm_controller

Overview:
- Downstream consumer of the combinational FallingDetector `fallDetected` flag.
- Filters out glitches by requiring the flag to stay high for several consecutive cycles before declaring a fall.
- On a confirmed fall, raises a local alarm, opens a patient-acknowledge window, and escalates to a remote (caregiver) alarm if the patient does not acknowledge in time.
- Keeps a saturating count of confirmed falls for the monitoring/display path.

Parameters:
CONFIRM_CYCLES, 4, consecutive cycles of fallDetected=1 needed to confirm a fall (legal range >= 2)
ACK_WINDOW, 16, cycles spent in ALERT before escalation (legal range >= 2)
CNT_W, 8, width of the fallCount register

Ports:
clk  input  1  system clock, rising-edge
rstN  input  1  asynchronous active-low reset
fallDetected  input  1  raw fall flag from FallingDetector, synchronous to clk
patientAck  input  1  patient "I am OK" button, level, synchronous
caregiverClear  input  1  caregiver reset of alarm, level, synchronous
alarmLocal  output  1  local buzzer/LED enable
alarmRemote  output  1  remote caregiver alert enable
alarmState  output  2  current FSM state encoding
fallCount  output  CNT_W  number of confirmed falls, saturating
eventPulse  output  1  one-cycle strobe on each confirmed fall

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rstN=0 immediately forces state=IDLE and clears all counters.
  - All outputs read 0 while reset is asserted, including fallCount and eventPulse.
  - Reset asserted in any state, including mid-ALERT or ESCALATED, aborts the alarm at once.
- State encoding: IDLE=2'd0, CONFIRM=2'd1, ALERT=2'd2, ESCALATED=2'd3.
- Outputs are all registered (Moore); none are combinational from inputs.
  - alarmLocal=1 in ALERT and ESCALATED.
  - alarmRemote=1 in ESCALATED only.
- IDLE:
  - fallDetected=1 -> CONFIRM, confCnt<=1.
  - patientAck and caregiverClear are ignored.
- CONFIRM:
  - fallDetected=0 -> IDLE, confCnt<=0 (glitch rejected, no count).
  - fallDetected=1 with confCnt==CONFIRM_CYCLES-1 -> ALERT, confCnt<=0.
  - fallDetected=1 otherwise -> confCnt++.
  - Net effect: ALERT is entered on the edge that samples the CONFIRM_CYCLES-th consecutive high.
  - patientAck and caregiverClear are ignored.
- Entry into ALERT, same edge:
  - fallCount <= fallCount+1, saturating at 2^CNT_W-1 (never wraps).
  - eventPulse<=1 for exactly one cycle, then 0.
  - ackTimer<=0.
- ALERT, evaluated each edge in this priority order:
  1. caregiverClear=1 or patientAck=1 -> IDLE.
  2. ackTimer==ACK_WINDOW-1 -> ESCALATED.
  3. Otherwise ackTimer++.
  - Ack/clear on the same cycle as the timeout wins: go to IDLE, no escalation.
  - Sequence: alarmLocal rises the cycle after the confirming edge and stays high ACK_WINDOW cycles; the next edge enters ESCALATED.
  - fallDetected is ignored; a continuous flag does not re-count.
- ESCALATED:
  - caregiverClear=1 -> IDLE.
  - patientAck is ignored.
  - fallDetected is ignored.
- Return to IDLE: timers are cleared. If fallDetected is still high, a new full confirmation (CONFIRM_CYCLES edges) is required; that re-trigger counts as a new fall.
- Widths: confCnt and ackTimer are sized by $clog2 of their parameter, minimum 1 bit. Comparisons are unsigned.

Test Plan:
- Glitch rejection: CONFIRM_CYCLES=4; fallDetected high for 3 edges then low -> alarmState 0->1->1->1->0, alarmLocal/eventPulse stay 0, fallCount=0.
- Confirmed fall, patient ack: fallDetected high for 4 edges -> after 4th edge alarmState=2, alarmLocal=1, eventPulse=1 for one cycle, fallCount=1; patientAck at ALERT cycle 5 -> next edge alarmState=0, alarmLocal=0, alarmRemote never 1.
- Escalation: confirmed fall with no ack -> after 16 cycles in ALERT, alarmState=3 and alarmRemote=1; patientAck pulses -> no change; caregiverClear=1 -> next edge alarmState=0, both alarms 0, fallCount still 1.
- Simultaneous ack and timeout: assert patientAck on the cycle where ackTimer=15 -> alarmState=0, alarmRemote stays 0.
- Reset mid-operation: in ESCALATED with fallCount=3, drop rstN between clock edges -> all outputs 0 immediately, without waiting for a clock; after rstN release with fallDetected=0, alarmState stays 0.
- Saturation: CNT_W=2; five confirmed falls, each cleared by patientAck -> fallCount reads 1,2,3,3,3; eventPulse fires on all 5.

Source files
------------

// File: rtl/fall_alarm_controller_if.sv
// Bundles the fall-alarm sensor/button inputs and alarm outputs into one port.
// The master side drives the raw flag and buttons; the slave side is the controller.
interface fall_alarm_controller_if #(
    parameter int CNT_W = 8
);
    logic             fallDetected;
    logic             patientAck;
    logic             caregiverClear;
    logic             alarmLocal;
    logic             alarmRemote;
    logic [1:0]       alarmState;
    logic [CNT_W-1:0] fallCount;
    logic             eventPulse;

    modport master (
        output fallDetected,
        output patientAck,
        output caregiverClear,
        input  alarmLocal,
        input  alarmRemote,
        input  alarmState,
        input  fallCount,
        input  eventPulse
    );

    modport slave (
        input  fallDetected,
        input  patientAck,
        input  caregiverClear,
        output alarmLocal,
        output alarmRemote,
        output alarmState,
        output fallCount,
        output eventPulse
    );
endinterface

// File: rtl/fall_alarm_controller.sv
// Fall alarm controller: debounces the raw fall flag, raises a local alarm on a
// confirmed fall, and escalates to the caregiver when the patient does not
// acknowledge within the window. Keeps a saturating tally of confirmed falls.
// All outputs come straight from flops so nothing downstream sees input glitches.
module fall_alarm_controller #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int ACK_WINDOW     = 16,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    fall_alarm_controller_if.slave  bus
);

    localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam int ACK_W  = (ACK_WINDOW > 1) ? $clog2(ACK_WINDOW) : 1;

    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONFIRM   = 2'd1,
        ALERT     = 2'd2,
        ESCALATED = 2'd3
    } state_t;

    state_t            state_r;
    state_t            nextState_s;
    logic [CONF_W-1:0] confCnt_r;
    logic [CONF_W-1:0] confCntNext_s;
    logic [ACK_W-1:0]  ackTimer_r;
    logic [ACK_W-1:0]  ackTimerNext_s;
    logic [CNT_W-1:0]  fallCount_r;
    logic [CNT_W-1:0]  fallCountNext_s;
    logic              eventPulse_r;
    logic              eventPulseNext_s;
    logic              alarmLocal_r;
    logic              alarmRemote_r;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Next-state, counter and strobe logic for the alarm FSM.
    always_comb begin
        nextState_s      = state_r;
        confCntNext_s    = confCnt_r;
        ackTimerNext_s   = ackTimer_r;
        fallCountNext_s  = fallCount_r;
        eventPulseNext_s = 1'b0;

        case (state_r)
            IDLE: begin
                // Buttons mean nothing here; only a rising fall flag matters.
                if (bus.fallDetected) begin
                    nextState_s   = CONFIRM;
                    confCntNext_s = CONF_W'(1);
                end else begin
                    confCntNext_s  = {CONF_W{1'b0}};
                    ackTimerNext_s = {ACK_W{1'b0}};
                end
            end

            CONFIRM: begin
                if (!bus.fallDetected) begin
                    // Flag dropped before confirmation: treat it as a glitch.
                    nextState_s   = IDLE;
                    confCntNext_s = {CONF_W{1'b0}};
                end else if (confCnt_r == CONF_LAST) begin
                    nextState_s      = ALERT;
                    confCntNext_s    = {CONF_W{1'b0}};
                    ackTimerNext_s   = {ACK_W{1'b0}};
                    fallCountNext_s  = satInc(fallCount_r);
                    eventPulseNext_s = 1'b1;
                end else begin
                    confCntNext_s = confCnt_r + CONF_W'(1);
                end
            end

            ALERT: begin
                // An acknowledge arriving on the timeout cycle still cancels escalation.
                if (bus.caregiverClear || bus.patientAck) begin
                    nextState_s    = IDLE;
                    ackTimerNext_s = {ACK_W{1'b0}};
                end else if (ackTimer_r == ACK_LAST) begin
                    nextState_s    = ESCALATED;
                    ackTimerNext_s = {ACK_W{1'b0}};
                end else begin
                    ackTimerNext_s = ackTimer_r + ACK_W'(1);
                end
            end

            ESCALATED: begin
                // Once the caregiver is alerted only the caregiver may stand it down.
                if (bus.caregiverClear) begin
                    nextState_s    = IDLE;
                    ackTimerNext_s = {ACK_W{1'b0}};
                end else begin
                    nextState_s = ESCALATED;
                end
            end

            default: begin
                nextState_s    = IDLE;
                confCntNext_s  = {CONF_W{1'b0}};
                ackTimerNext_s = {ACK_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered Moore outputs; reset aborts any alarm at once.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r       <= IDLE;
            confCnt_r     <= {CONF_W{1'b0}};
            ackTimer_r    <= {ACK_W{1'b0}};
            fallCount_r   <= {CNT_W{1'b0}};
            eventPulse_r  <= 1'b0;
            alarmLocal_r  <= 1'b0;
            alarmRemote_r <= 1'b0;
        end else begin
            state_r       <= nextState_s;
            confCnt_r     <= confCntNext_s;
            ackTimer_r    <= ackTimerNext_s;
            fallCount_r   <= fallCountNext_s;
            eventPulse_r  <= eventPulseNext_s;
            alarmLocal_r  <= (nextState_s == ALERT) || (nextState_s == ESCALATED);
            alarmRemote_r <= (nextState_s == ESCALATED);
        end
    end

    assign bus.alarmState  = state_r;
    assign bus.alarmLocal  = alarmLocal_r;
    assign bus.alarmRemote = alarmRemote_r;
    assign bus.fallCount   = fallCount_r;
    assign bus.eventPulse  = eventPulse_r;

endmodule

// File: tb/tb_fall_alarm_controller.sv
// Directed bench for fall_alarm_controller: glitch rejection, acknowledge,
// escalation, ack-on-timeout, asynchronous reset and fall-count saturation.
module tb_fall_alarm_controller;

    localparam int CC = 4;
    localparam int AW = 16;
    localparam int CW = 2;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    fall_alarm_controller_if #(.CNT_W(CW)) bus ();

    fall_alarm_controller #(
        .CONFIRM_CYCLES (CC),
        .ACK_WINDOW     (AW),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOuts(input string tag, input logic [1:0] st, input logic loc,
                             input logic rem, input logic [CW-1:0] cnt, input logic pls);
        check({tag, ".state"},  {30'd0, bus.alarmState}, {30'd0, st});
        check({tag, ".local"},  {31'd0, bus.alarmLocal}, {31'd0, loc});
        check({tag, ".remote"}, {31'd0, bus.alarmRemote}, {31'd0, rem});
        check({tag, ".count"},  {30'd0, bus.fallCount}, {30'd0, cnt});
        check({tag, ".pulse"},  {31'd0, bus.eventPulse}, {31'd0, pls});
    endtask

    // Hold the flag high for CC edges and check the ALERT entry on the last one.
    task automatic confirmFall(input string tag, input logic [CW-1:0] expCnt);
        bus.fallDetected = 1'b1;
        for (int i = 0; i < CC - 1; i++) begin
            step();
            check({tag, ".confirming"}, {30'd0, bus.alarmState}, 32'd1);
        end
        step();
        checkOuts({tag, ".entry"}, 2'd2, 1'b1, 1'b0, expCnt, 1'b1);
        bus.fallDetected = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        bus.fallDetected   = 1'b0;
        bus.patientAck     = 1'b0;
        bus.caregiverClear = 1'b0;

        // Reset state
        step();
        step();
        checkOuts("reset", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        rstN = 1'b1;
        step();
        checkOuts("idle", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Glitch rejection: three highs then low, with buttons pressed (ignored)
        bus.fallDetected = 1'b1;
        bus.patientAck   = 1'b1;
        step();
        checkOuts("glitch1", 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        bus.patientAck     = 1'b0;
        bus.caregiverClear = 1'b1;
        step();
        checkOuts("glitch2", 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        bus.caregiverClear = 1'b0;
        step();
        checkOuts("glitch3", 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        bus.fallDetected = 1'b0;
        step();
        checkOuts("glitch4", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Confirmed fall, flag held high in ALERT (no re-count), then patient ack
        confirmFall("fall1", 2'd1);
        bus.fallDetected = 1'b1;
        step();
        checkOuts("fall1.hold1", 2'd2, 1'b1, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        checkOuts("fall1.hold6", 2'd2, 1'b1, 1'b0, 2'd1, 1'b0);
        bus.fallDetected = 1'b0;
        bus.patientAck   = 1'b1;
        step();
        checkOuts("fall1.ack", 2'd0, 1'b0, 1'b0, 2'd1, 1'b0);
        bus.patientAck = 1'b0;

        // Escalation: 16 cycles in ALERT, then ESCALATED; ack ignored; clear returns
        confirmFall("esc", 2'd2);
        for (int i = 0; i < AW - 1; i++) begin
            step();
        end
        checkOuts("esc.lastAlert", 2'd2, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        checkOuts("esc.enter", 2'd3, 1'b1, 1'b1, 2'd2, 1'b0);
        bus.patientAck   = 1'b1;
        bus.fallDetected = 1'b1;
        step();
        checkOuts("esc.ackIgnored", 2'd3, 1'b1, 1'b1, 2'd2, 1'b0);
        bus.patientAck   = 1'b0;
        bus.fallDetected = 1'b0;
        step();
        checkOuts("esc.hold", 2'd3, 1'b1, 1'b1, 2'd2, 1'b0);
        bus.caregiverClear = 1'b1;
        step();
        checkOuts("esc.clear", 2'd0, 1'b0, 1'b0, 2'd2, 1'b0);
        bus.caregiverClear = 1'b0;

        // Ack on the timeout cycle (ackTimer at its last value) wins
        confirmFall("tmo", 2'd3);
        for (int i = 0; i < AW - 1; i++) begin
            step();
        end
        checkOuts("tmo.lastAlert", 2'd2, 1'b1, 1'b0, 2'd3, 1'b0);
        bus.patientAck = 1'b1;
        step();
        checkOuts("tmo.ack", 2'd0, 1'b0, 1'b0, 2'd3, 1'b0);
        bus.patientAck = 1'b0;
        step();
        check("tmo.stayIdle", {30'd0, bus.alarmState}, 32'd0);

        // Reset mid-ESCALATED with count at 3 (this fall saturates the count)
        confirmFall("rst", 2'd3);
        for (int i = 0; i < AW; i++) begin
            step();
        end
        checkOuts("rst.escalated", 2'd3, 1'b1, 1'b1, 2'd3, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOuts("rst.async", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        checkOuts("rst.held", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        rstN = 1'b1;
        step();
        step();
        checkOuts("rst.after", 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Saturation: five falls, each acknowledged
        for (int n = 1; n <= 5; n++) begin
            confirmFall($sformatf("sat%0d", n), (n >= 3) ? 2'd3 : CW'(n));
            bus.patientAck = 1'b1;
            step();
            checkOuts($sformatf("sat%0d.ack", n), 2'd0, 1'b0, 1'b0,
                      (n >= 3) ? 2'd3 : CW'(n), 1'b0);
            bus.patientAck = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
